// File: rtl/conv_layer_sched.sv
// conv_layer_sched: steps the conv units through clear / accumulate / write-back
// for each half-row of every output row, once per filter, for one layer run.
module conv_layer_sched #(
  parameter int unsigned D = 1,
  parameter int unsigned S = 5,
  parameter int unsigned H = 32,
  parameter int unsigned W = 32,
  parameter int unsigned K = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(H-S+1):0]          row_num,
  output logic [$clog2(W-S+1):0]          col_sel,
  output logic [$clog2(K):0]              filt_idx,
  output logic                            cu_rst,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [$clog2(2*(H-S+1)):0]      res_idx
);

  localparam int unsigned OH       = H - S + 1;
  localparam int unsigned OW       = W - S + 1;
  localparam int unsigned NCU      = OW / 2;
  localparam int unsigned ACC_LAST = D * S * S + 1;
  localparam int unsigned RW       = $clog2(OH) + 1;
  localparam int unsigned CSW      = $clog2(OW) + 1;
  localparam int unsigned FW       = $clog2(K) + 1;
  localparam int unsigned IW       = $clog2(2 * OH) + 1;
  localparam int unsigned CNTW     = $clog2(ACC_LAST + 1) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state, nxt_state;
  logic [CNTW-1:0] cnt, nxt_cnt;
  logic [RW-1:0]   nxt_row;
  logic [CSW-1:0]  nxt_col;
  logic [FW-1:0]   nxt_filt;
  logic [IW-1:0]   nxt_idx;
  logic            nxt_busy, nxt_done, nxt_cu_rst, nxt_valid;

  // next-state and next-output decode; every output is registered from these
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_row   = row_num;
    nxt_col   = col_sel;
    nxt_filt  = filt_idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt_state = CLEAR;
          nxt_row   = '0;
          nxt_col   = '0;
          nxt_filt  = '0;
        end
      end
      CLEAR: begin
        nxt_state = ACCUM;
        nxt_cnt   = '0;
      end
      ACCUM: begin
        if (cnt == CNTW'(ACC_LAST)) nxt_state = WRITE;
        else                        nxt_cnt   = cnt + CNTW'(1);
      end
      WRITE: begin
        // walk half-rows, then rows, then filters; hold everything while stalled
        if (res_ready) begin
          if (col_sel == '0) begin
            nxt_col   = CSW'(NCU);
            nxt_state = CLEAR;
          end else if ((32'(row_num) + 32'd1) < OH) begin
            nxt_row   = row_num + RW'(1);
            nxt_col   = '0;
            nxt_state = CLEAR;
          end else if ((32'(filt_idx) + 32'd1) < K) begin
            nxt_filt  = filt_idx + FW'(1);
            nxt_row   = '0;
            nxt_col   = '0;
            nxt_state = CLEAR;
          end else begin
            nxt_state = DONE;
          end
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    nxt_busy   = (nxt_state != IDLE);
    nxt_done   = (nxt_state == DONE);
    nxt_cu_rst = (nxt_state == CLEAR);
    nxt_valid  = (nxt_state == WRITE);
    nxt_idx    = (IW'(nxt_row) << 1) | IW'(nxt_col != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cu_rst    <= 1'b1;
      res_valid <= 1'b0;
      row_num   <= '0;
      col_sel   <= '0;
      filt_idx  <= '0;
      res_idx   <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      busy      <= nxt_busy;
      done      <= nxt_done;
      cu_rst    <= nxt_cu_rst;
      res_valid <= nxt_valid;
      row_num   <= nxt_row;
      col_sel   <= nxt_col;
      filt_idx  <= nxt_filt;
      res_idx   <= nxt_idx;
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: two instances (K=1, K=2) on a 6x6 image with a
// 3x3 filter, checked cycle by cycle against a pass-timing reference model.
module tb_conv_layer_sched;

  localparam int D   = 1;
  localparam int S   = 3;
  localparam int H   = 6;
  localparam int W   = 6;
  localparam int OH  = H - S + 1;
  localparam int NCU = (W - S + 1) / 2;
  localparam int P   = D * S * S + 4;
  localparam int RW  = $clog2(OH) + 1;
  localparam int CW  = $clog2(W - S + 1) + 1;
  localparam int IW  = $clog2(2 * OH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic res_ready = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;

  logic          busy1, done1, cu_rst1, valid1;
  logic [RW-1:0] row1;
  logic [CW-1:0] col1;
  logic [0:0]    filt1;
  logic [IW-1:0] idx1;

  logic          busy2, done2, cu_rst2, valid2;
  logic [RW-1:0] row2;
  logic [CW-1:0] col2;
  logic [1:0]    filt2;
  logic [IW-1:0] idx2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_layer_sched #(.D(D), .S(S), .H(H), .W(W), .K(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .row_num(row1), .col_sel(col1), .filt_idx(filt1), .cu_rst(cu_rst1),
    .res_valid(valid1), .res_ready(res_ready), .res_idx(idx1));

  conv_layer_sched #(.D(D), .S(S), .H(H), .W(W), .K(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .row_num(row2), .col_sel(col2), .filt_idx(filt2), .cu_rst(cu_rst2),
    .res_valid(valid2), .res_ready(res_ready), .res_idx(idx2));

  // Reference: cycle 0 is the accept cycle; pass p occupies P cycles starting at
  // 1+p*P, its last cycle is the write; one optional stall lengthens pass sp.
  function automatic void model(input int k, input int sp, input int sl, input int n,
                                output logic [3:0] ctl, output int idx, output int row,
                                output int col, output int filt);
    int passes, total, s, wl;
    logic b, d, v, cr;
    passes = 2 * OH * k;
    total  = passes * P + 1 + ((sp >= 0 && sp < passes) ? sl : 0);
    b = (n >= 1 && n <= total);
    d = (n == total);
    v = 1'b0; cr = 1'b0;
    idx = 0; row = 0; col = 0; filt = 0;
    for (int p = 0; p < passes; p++) begin
      s  = 1 + p * P + ((sp >= 0 && p > sp) ? sl : 0);
      wl = (p == sp) ? sl + 1 : 1;
      if (n == s) cr = 1'b1;
      if (n >= s + P - 1 && n < s + P - 1 + wl) begin
        v    = 1'b1;
        idx  = p % (2 * OH);
        row  = (p % (2 * OH)) / 2;
        col  = (p % 2) ? NCU : 0;
        filt = p / (2 * OH);
      end
    end
    ctl = {b, d, v, cr};
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, valid1, cu_rst1, idx1, row1, col1, filt1} !== {4'b0001, IW'(0), RW'(0), CW'(0), 1'b0}) begin
      failures++;
      $display("FAIL reset_k1 got %b/%0d/%0d/%0d/%0d exp 0001/0/0/0/0",
               {busy1, done1, valid1, cu_rst1}, idx1, row1, col1, filt1);
    end
    checks++;
    if ({busy2, done2, valid2, cu_rst2, idx2, filt2} !== {4'b0001, IW'(0), 2'b00}) begin
      failures++;
      $display("FAIL reset_k2 got %b/%0d/%0d exp 0001/0/0", {busy2, done2, valid2, cu_rst2}, idx2, filt2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy1, done1, valid1, cu_rst1, busy2, done2, valid2, cu_rst2} !== 8'h00) begin
      failures++;
      $display("FAIL idle_after_reset got %b %b exp 0000 0000",
               {busy1, done1, valid1, cu_rst1}, {busy2, done2, valid2, cu_rst2});
    end
  endtask

  task automatic test_single_filter();
    logic [3:0] ec;
    int ei, er, ecol, ef, nval, lastv;
    int total = 2 * OH * P + 1;
    nval = 0; lastv = -1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 1; n <= total + 2; n++) begin
      model(1, -1, 0, n, ec, ei, er, ecol, ef);
      checks++;
      if ({busy1, done1, valid1, cu_rst1} !== ec) begin
        failures++;
        $display("FAIL single_ctl cycle %0d got %b exp %b", n, {busy1, done1, valid1, cu_rst1}, ec);
      end
      if (valid1) begin
        if (lastv >= 0) begin
          checks++;
          if (n - lastv != P) begin
            failures++;
            $display("FAIL single_spacing cycle %0d got %0d exp %0d", n, n - lastv, P);
          end
        end
        lastv = n;
        nval++;
      end
      if (ec[1]) begin
        checks++;
        if ({idx1, row1, col1, filt1} !== {IW'(ei), RW'(er), CW'(ecol), 1'(ef)}) begin
          failures++;
          $display("FAIL single_slot cycle %0d got idx=%0d row=%0d col=%0d f=%0d exp %0d/%0d/%0d/%0d",
                   n, idx1, row1, col1, filt1, ei, er, ecol, ef);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nval != 2 * OH) begin
      failures++;
      $display("FAIL single_count got %0d exp %0d", nval, 2 * OH);
    end
  endtask

  task automatic test_two_filters();
    logic [3:0] ec;
    int ei, er, ecol, ef, nval;
    int total = 4 * OH * P + 1;
    nval = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 1; n <= total + 2; n++) begin
      model(2, -1, 0, n, ec, ei, er, ecol, ef);
      checks++;
      if ({busy2, done2, valid2, cu_rst2} !== ec) begin
        failures++;
        $display("FAIL two_ctl cycle %0d got %b exp %b", n, {busy2, done2, valid2, cu_rst2}, ec);
      end
      if (valid2) nval++;
      if (ec[1]) begin
        checks++;
        if ({idx2, row2, col2, filt2} !== {IW'(ei), RW'(er), CW'(ecol), 2'(ef)}) begin
          failures++;
          $display("FAIL two_slot cycle %0d got idx=%0d row=%0d col=%0d f=%0d exp %0d/%0d/%0d/%0d",
                   n, idx2, row2, col2, filt2, ei, er, ecol, ef);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nval != 4 * OH) begin
      failures++;
      $display("FAIL two_count got %0d exp %0d", nval, 4 * OH);
    end
  endtask

  task automatic test_stall();
    logic [3:0] ec;
    int ei, er, ecol, ef, sp, sl, wstart, total;
    for (int it = 0; it < 2; it++) begin
      sp = (it == 0) ? 2 : int'($urandom_range(0, 2 * OH - 1));
      sl = (it == 0) ? 5 : int'($urandom_range(1, 7));
      wstart = (sp + 1) * P;
      total  = 2 * OH * P + 1 + sl;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int n = 1; n <= total + 2; n++) begin
        res_ready = !(n >= wstart && n < wstart + sl);
        model(1, sp, sl, n, ec, ei, er, ecol, ef);
        checks++;
        if ({busy1, done1, valid1, cu_rst1} !== ec) begin
          failures++;
          $display("FAIL stall_ctl it %0d cycle %0d got %b exp %b", it, n, {busy1, done1, valid1, cu_rst1}, ec);
        end
        if (ec[1]) begin
          checks++;
          if ({idx1, row1, col1, filt1} !== {IW'(ei), RW'(er), CW'(ecol), 1'(ef)}) begin
            failures++;
            $display("FAIL stall_slot it %0d cycle %0d got idx=%0d row=%0d col=%0d exp %0d/%0d/%0d",
                     it, n, idx1, row1, col1, ei, er, ecol);
          end
        end
        @(negedge clk);
      end
      res_ready = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] ec;
    int ei, er, ecol, ef, rn;
    int total = 2 * OH * P + 1;
    rn = int'($urandom_range(3 * P + 2, 4 * P - 1));
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 1; n < rn; n++) begin
      model(1, -1, 0, n, ec, ei, er, ecol, ef);
      checks++;
      if ({busy1, done1, valid1, cu_rst1} !== ec) begin
        failures++;
        $display("FAIL midrst_pre cycle %0d got %b exp %b", n, {busy1, done1, valid1, cu_rst1}, ec);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, valid1, cu_rst1, idx1, row1, col1, filt1} !== {4'b0001, IW'(0), RW'(0), CW'(0), 1'b0}) begin
      failures++;
      $display("FAIL midrst_async got %b idx=%0d row=%0d col=%0d exp 0001 0/0/0",
               {busy1, done1, valid1, cu_rst1}, idx1, row1, col1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3 * P; n++) begin
      @(negedge clk);
      checks++;
      if ({busy1, done1, valid1, cu_rst1} !== 4'b0000) begin
        failures++;
        $display("FAIL midrst_idle cycle %0d got %b exp 0000", n, {busy1, done1, valid1, cu_rst1});
      end
    end
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 1; n <= total + 1; n++) begin
      model(1, -1, 0, n, ec, ei, er, ecol, ef);
      checks++;
      if ({busy1, done1, valid1, cu_rst1} !== ec) begin
        failures++;
        $display("FAIL midrst_rerun_ctl cycle %0d got %b exp %b", n, {busy1, done1, valid1, cu_rst1}, ec);
      end
      if (ec[1]) begin
        checks++;
        if (idx1 !== IW'(ei)) begin
          failures++;
          $display("FAIL midrst_rerun_idx cycle %0d got %0d exp %0d", n, idx1, ei);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    logic [3:0] ec;
    int ei, er, ecol, ef, b1, b2;
    int total = 2 * OH * P + 1;
    b1 = int'($urandom_range(2, P * 4));
    b2 = int'($urandom_range(P * 4 + 1, total - 1));
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= total + 4; n++) begin
      start1 = (n == b1 || n == b2 || n == total);
      model(1, -1, 0, n, ec, ei, er, ecol, ef);
      checks++;
      if ({busy1, done1, valid1, cu_rst1} !== ec) begin
        failures++;
        $display("FAIL ignore_ctl cycle %0d got %b exp %b", n, {busy1, done1, valid1, cu_rst1}, ec);
      end
      if (ec[1]) begin
        checks++;
        if (idx1 !== IW'(ei)) begin
          failures++;
          $display("FAIL ignore_idx cycle %0d got %0d exp %0d", n, idx1, ei);
        end
      end
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ec;
    int ei, er, ecol, ef, m;
    int total = 2 * OH * P + 1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 2 * total + 3; n++) begin
      start1 = (n == total || n == total + 1);
      m = (n <= total + 1) ? n : n - total - 1;
      model(1, -1, 0, m, ec, ei, er, ecol, ef);
      checks++;
      if ({busy1, done1, valid1, cu_rst1} !== ec) begin
        failures++;
        $display("FAIL b2b_ctl cycle %0d got %b exp %b", n, {busy1, done1, valid1, cu_rst1}, ec);
      end
      if (ec[1]) begin
        checks++;
        if (idx1 !== IW'(ei)) begin
          failures++;
          $display("FAIL b2b_idx cycle %0d got %0d exp %0d", n, idx1, ei);
        end
      end
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_filter();
    test_two_filters();
    test_stall();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_layer_sched.md
CONV_LAYER_SCHED -- requirements
Module: conv_layer_sched

Interface
REQ-001 The block SHALL have parameter D, default 1, meaning filter depth.
REQ-002 The block SHALL have parameter S, default 5, meaning filter size.
REQ-003 The block SHALL have parameter H, default 32, meaning image height.
REQ-004 The block SHALL have parameter W, default 32, meaning image width; (W-S+1) is even, with OH=H-S+1, OW=W-S+1, NCU=OW/2.
REQ-005 The block SHALL have parameter K, default 4, meaning number of filters processed per layer run.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit, reset: asynchronous, active-low.
REQ-008 The block SHALL have port start, input, 1 bit, the layer-run request, sampled in IDLE only.
REQ-009 The block SHALL have port busy, output, 1 bit, high from the cycle after start is accepted until DONE exits.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse at run completion.
REQ-011 The block SHALL have port row_num, output, $clog2(OH)+1 bits, the output row fed to the region selector.
REQ-012 The block SHALL have port col_sel, output, $clog2(OW)+1 bits, the column offset: 0 or NCU.
REQ-013 The block SHALL have port filt_idx, output, $clog2(K)+1 bits, the active filter / kernel-bank select.
REQ-014 The block SHALL have port cu_rst, output, 1 bit, the synchronous clear for all conv units.
REQ-015 The block SHALL have port res_valid, output, 1 bit, meaning cuRes holds a finished half-row.
REQ-016 The block SHALL have port res_ready, input, 1 bit, meaning the result buffer accepts the half-row.
REQ-017 The block SHALL have port res_idx, output, $clog2(2*OH)+1 bits, the half-row slot index = 2*row_num + (col_sel!=0).

Function
REQ-018 The FSM SHALL use states IDLE, CLEAR, ACCUM, WRITE and DONE, each lasting 1 cycle unless stated.
REQ-019 In IDLE with start=1, the FSM SHALL go to CLEAR with row_num=0, col_sel=0, filt_idx=0; start is ignored in any other state.
REQ-020 In CLEAR, cu_rst SHALL be 1, and the FSM SHALL then go to ACCUM with the cycle counter at 0.
REQ-021 ACCUM SHALL last exactly D*S*S+2 cycles (counter 0..D*S*S+1), with cu_rst=0; on the final count the FSM SHALL go to WRITE.
REQ-022 In WRITE, res_valid SHALL be 1, and row_num/col_sel/filt_idx/res_idx SHALL be held stable until res_ready=1.
REQ-023 The transfer SHALL complete in the cycle where res_valid && res_ready; res_valid SHALL drop the next cycle, and the block SHALL advance as follows:
- col_sel=0 -> col_sel=NCU, same row;
- col_sel=NCU and row_num<OH-1 -> row_num+1, col_sel=0;
- last row and filt_idx<K-1 -> filt_idx+1, row_num=0, col_sel=0;
- otherwise -> DONE.
REQ-024 Every advance other than the move to DONE SHALL re-enter CLEAR.
REQ-025 In DONE, done SHALL be 1 for one cycle and busy SHALL be 1; the FSM SHALL then go to IDLE and busy SHALL drop.
REQ-026 res_ready held low SHALL stall the FSM in WRITE indefinitely, with no counter advance and no cu_rst.
REQ-027 The latency of one pass SHALL be (D*S*S+4) cycles with res_ready=1.
REQ-028 A full run SHALL take 2*OH*K passes plus 1 DONE cycle after start acceptance.
REQ-029 All counters SHALL be sized so no wrap occurs within a run; res_idx SHALL never exceed 2*OH-1.
REQ-030 A start asserted in the same cycle as done SHALL be ignored; a start held high in the following IDLE cycle SHALL be accepted.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, busy=0, done=0, res_valid=0, cu_rst=1, row_num=0, col_sel=0, filt_idx=0, res_idx=0, counter=0.
REQ-032 cu_rst SHALL fall to 0 in IDLE after the first clock with rst_n=1.
REQ-033 A reset asserted mid-run SHALL abort the run with no done pulse; a new start SHALL be required afterwards.

Verification
REQ-034 The bench SHALL cover: D=1,S=3,H=W=6,K=1, res_ready=1, start pulse -> 8 res_valid pulses with res_idx 0..7 in order, each 13 cycles apart, then done exactly 105 cycles after start acceptance.
REQ-035 The bench SHALL cover: same configuration with K=2 -> 16 transfers, with filt_idx=0 for the first 8 and 1 for the last 8; res_idx restarts at 0; done after 209 cycles.
REQ-036 The bench SHALL cover: res_ready=0 for 5 cycles during the third WRITE -> res_valid high 6 cycles, row_num=1, col_sel=0, res_idx=2 stable, and total run length +5.
REQ-037 The bench SHALL cover: rst_n low during ACCUM of pass 4 -> outputs at reset values immediately, no done; a re-start gives res_idx from 0.
REQ-038 The bench SHALL cover: start pulsed while busy, and start pulsed on the done cycle -> ignored, with no restart and no change to sequence.
REQ-039 The bench SHALL cover: cu_rst high exactly 1 cycle before every ACCUM, and 0 in WRITE, DONE and idle-after-reset.
